rv32i_id_pipe_stage: RTL and testbench

Registered RV32I decode stage: decodes the IF/ID payload, reads the register file, resolves operands through a parametrised set of write-back forwarding ports, and holds the result in an ID/EX register with a valid/ready handshake on both sides. It adds load-use interlock, flush, and optional pass-through of illegal instructions as tagged exceptions instead of silently dropping them. It sits between the fetch stage and the EX stage.

---
 rtl/rv32i_core_pkg.sv | 92 +++++++++
 rtl/rv32i_decoder.sv | 93 +++++++++
 rtl/rv32i_imm_gen.sv | 26 ++
 rtl/rv32i_operand_fwd.sv | 35 +++
 rtl/rv32i_id_pipe_stage.sv | 150 +++++++++++++++
 tb/tb_rv32i_id_pipe_stage.sv | 321 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rv32i_core_pkg.sv
// Shared RV32I core types: opcodes, decode control, stage payloads and
// forwarding sources.
package rv32i_core_pkg;

  localparam int MAX_FWD = 4;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;

  localparam logic [3:0] EXC_CAUSE_ILLEGAL = 4'd2;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} op_a_sel_t;
  typedef enum logic       {OPB_RS2, OPB_IMM} op_b_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } fwd_src_t;

  typedef struct packed {
    logic       illegal;
    logic [3:0] cause;
  } id_ex_exc_t;

  typedef struct packed {
    alu_op_t    alu_op;
    op_a_sel_t  op_a_sel;
    op_b_sel_t  op_b_sel;
    logic [2:0] funct3;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    alu_op_t     alu_op;
    op_a_sel_t   op_a_sel;
    op_b_sel_t   op_b_sel;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
  } id_ex_payload_t;

  function automatic alu_op_t alu_op_from(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// RV32I control decoder: control fields, illegal detection and which source
// registers the instruction actually reads.
module rv32i_decoder
  import rv32i_core_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o
);

  ctrl_t ctrl;
  logic  illegal;

  always_comb begin
    ctrl        = '0;
    ctrl.funct3 = funct3_i;
    illegal     = 1'b0;
    case (opcode_i)
      OPC_LUI: begin
        ctrl.op_a_sel  = OPA_ZERO;
        ctrl.op_b_sel  = OPB_IMM;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        ctrl.op_a_sel  = OPA_PC;
        ctrl.op_b_sel  = OPB_IMM;
        ctrl.reg_write = 1'b1;
        ctrl.jump      = (opcode_i == OPC_JAL);
      end
      OPC_JALR: begin
        ctrl.op_b_sel  = OPB_IMM;
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.jalr      = 1'b1;
        illegal        = (funct3_i != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        illegal     = (funct3_i[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        ctrl.op_b_sel  = OPB_IMM;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        illegal        = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
      end
      OPC_STORE: begin
        ctrl.op_b_sel  = OPB_IMM;
        ctrl.mem_write = 1'b1;
        illegal        = (funct3_i[2] || funct3_i == 3'b011);
      end
      OPC_OP_IMM: begin
        ctrl.op_b_sel  = OPB_IMM;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = alu_op_from(funct3_i, funct7_i[5] && funct3_i == 3'b101);
        // Shift immediates reuse funct7; only SRAI may set bit 5.
        if (funct3_i == 3'b001)
          illegal = (funct7_i != 7'h00);
        else if (funct3_i == 3'b101)
          illegal = ((funct7_i & 7'b1011111) != 7'h00);
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = alu_op_from(funct3_i, funct7_i[5]);
        illegal        = (funct7_i != 7'h00) &&
                         !(funct7_i == 7'h20 && (funct3_i == 3'b000 || funct3_i == 3'b101));
      end
      OPC_MISC_MEM: begin
        ctrl.op_a_sel = OPA_ZERO;
        ctrl.op_b_sel = OPB_IMM;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.jalr      = 1'b0;
    end
  end

  assign ctrl_o     = ctrl;
  assign illegal_o  = illegal;
  assign rs1_used_o = !illegal && (ctrl.op_a_sel == OPA_RS1);
  assign rs2_used_o = !illegal && (ctrl.op_b_sel == OPB_RS2 || ctrl.branch || ctrl.mem_write);

endmodule

// File: rtl/rv32i_imm_gen.sv
// RV32I immediate extraction, selected by opcode; unknown opcodes give 0.
module rv32i_imm_gen
  import rv32i_core_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (instr_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'h000};
      OPC_JAL:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_operand_fwd.sv
// Priority forwarding mux for one source operand; index 0 is the youngest
// producer and wins, x0 always reads zero.
module rv32i_operand_fwd
  import rv32i_core_pkg::*;
#(
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]               addr_i,
  input  logic [31:0]              rf_data_i,
  input  fwd_src_t [NUM_FWD-1:0]   src_i,
  output logic [31:0]              data_o
);

  fwd_src_t [MAX_FWD-1:0] src_pad;

  for (genvar gi = 0; gi < MAX_FWD; gi++) begin : g_pad
    if (gi < NUM_FWD) begin : g_used
      assign src_pad[gi] = src_i[gi];
    end else begin : g_empty
      assign src_pad[gi] = '0;
    end
  end

  always_comb begin
    data_o = rf_data_i;
    // Walk from oldest to youngest so the lowest matching index is applied last.
    for (int i = MAX_FWD - 1; i >= 0; i--) begin
      if (src_pad[i].valid && src_pad[i].rd == addr_i)
        data_o = src_pad[i].data;
    end
    if (addr_i == 5'd0)
      data_o = '0;
  end

endmodule

// File: rtl/rv32i_id_pipe_stage.sv
// RV32I decode stage with operand forwarding, load-use interlock, flush and
// an ID/EX register behind a valid/ready handshake.
module rv32i_id_pipe_stage
  import rv32i_core_pkg::*;
#(
  parameter int NUM_FWD        = 2,
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter bit ILLEGAL_PASS   = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      if_valid_i,
  output logic                      if_ready_o,
  input  if_id_payload_t            if_payload_i,
  input  logic                      flush_i,
  output logic [4:0]                rf_rs1_addr_o,
  output logic [4:0]                rf_rs2_addr_o,
  input  logic [31:0]               rf_rs1_data_i,
  input  logic [31:0]               rf_rs2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_valid_i,
  input  logic [NUM_FWD-1:0][4:0]   fwd_rd_i,
  input  logic [NUM_FWD-1:0][31:0]  fwd_data_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output id_ex_payload_t            ex_payload_o,
  output logic                      ex_illegal_o,
  output logic                      hazard_stall_o
);

  logic [31:0] instr;
  logic [4:0]  rs1_addr, rs2_addr;
  ctrl_t       ctrl;
  logic        illegal, rs1_used, rs2_used;
  logic [31:0] imm, rs1_data, rs2_data;
  fwd_src_t [NUM_FWD-1:0] fwd_src;

  assign instr    = if_payload_i.instr;
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rf_rs1_addr_o = rs1_addr;
  assign rf_rs2_addr_o = rs2_addr;

  for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
    assign fwd_src[gi] = '{valid: fwd_valid_i[gi], rd: fwd_rd_i[gi], data: fwd_data_i[gi]};
  end

  rv32i_decoder u_decoder (
    .opcode_i   (instr[6:0]),
    .funct3_i   (instr[14:12]),
    .funct7_i   (instr[31:25]),
    .ctrl_o     (ctrl),
    .illegal_o  (illegal),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used)
  );

  rv32i_imm_gen u_imm_gen (
    .instr_i (instr),
    .imm_o   (imm)
  );

  rv32i_operand_fwd #(.NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .addr_i    (rs1_addr),
    .rf_data_i (rf_rs1_data_i),
    .src_i     (fwd_src),
    .data_o    (rs1_data)
  );

  rv32i_operand_fwd #(.NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .addr_i    (rs2_addr),
    .rf_data_i (rf_rs2_data_i),
    .src_i     (fwd_src),
    .data_o    (rs2_data)
  );

  logic           ex_valid_q, ex_valid_d;
  id_ex_payload_t payload_q, payload_d;
  id_ex_exc_t     exc_q, exc_d;
  id_ex_payload_t decoded;
  logic           load_en, hazard, issue_valid;

  always_comb begin
    decoded           = '0;
    decoded.pc        = if_payload_i.pc;
    decoded.pc_plus4  = if_payload_i.pc + 32'd4;
    decoded.instr     = instr;
    decoded.imm       = imm;
    decoded.rs1_data  = rs1_data;
    decoded.rs2_data  = rs2_data;
    decoded.rs1_addr  = rs1_addr;
    decoded.rs2_addr  = rs2_addr;
    decoded.rd_addr   = instr[11:7];
    decoded.alu_op    = ctrl.alu_op;
    decoded.op_a_sel  = ctrl.op_a_sel;
    decoded.op_b_sel  = ctrl.op_b_sel;
    decoded.funct3    = ctrl.funct3;
    decoded.reg_write = ctrl.reg_write;
    decoded.mem_read  = ctrl.mem_read;
    decoded.mem_write = ctrl.mem_write;
    decoded.branch    = ctrl.branch;
    decoded.jump      = ctrl.jump;
    decoded.jalr      = ctrl.jalr;
  end

  assign load_en = !ex_valid_q || ex_ready_i;

  // A pending flush kills the consumer anyway, so it never needs a bubble.
  assign hazard = LOAD_USE_STALL && !flush_i && if_valid_i && ex_valid_q &&
                  payload_q.mem_read && (payload_q.rd_addr != 5'd0) &&
                  ((rs1_used && rs1_addr == payload_q.rd_addr) ||
                   (rs2_used && rs2_addr == payload_q.rd_addr));

  assign issue_valid = if_valid_i && (!illegal || ILLEGAL_PASS);

  always_comb begin
    ex_valid_d = ex_valid_q;
    payload_d  = payload_q;
    exc_d      = exc_q;
    if (flush_i || (load_en && hazard)) begin
      ex_valid_d = 1'b0;
      payload_d  = '0;
      exc_d      = '0;
    end else if (load_en) begin
      ex_valid_d    = issue_valid;
      payload_d     = issue_valid ? decoded : '0;
      exc_d.illegal = issue_valid && illegal;
      exc_d.cause   = (issue_valid && illegal) ? EXC_CAUSE_ILLEGAL : 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q <= 1'b0;
      payload_q  <= '0;
      exc_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      payload_q  <= payload_d;
      exc_q      <= exc_d;
    end
  end

  assign if_ready_o     = flush_i || (load_en && !hazard);
  assign hazard_stall_o = hazard;
  assign ex_valid_o     = ex_valid_q;
  assign ex_payload_o   = payload_q;
  // The cause field is spare today; qualifying on it keeps later causes from aliasing.
  assign ex_illegal_o   = exc_q.illegal && (exc_q.cause == EXC_CAUSE_ILLEGAL);

endmodule

// File: tb/tb_rv32i_id_pipe_stage.sv
// Directed plus randomized bench for rv32i_id_pipe_stage against a
// transaction-level model; instance 1 runs with illegal pass-through disabled.
module tb_rv32i_id_pipe_stage;
  import rv32i_core_pkg::*;

  typedef enum int {K_ADDI, K_ADD, K_LW, K_SW, K_BEQ, K_LUI, K_ILL} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
  } tx_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                v_in, rdy_in, fl_in;
  logic [1:0]          fv;
  logic [1:0][4:0]     frd;
  logic [1:0][31:0]    fd;
  tx_t                 cur;
  if_id_payload_t      pin;
  logic [31:0]         rf [32];

  logic            if_ready [2];
  logic            hz       [2];
  logic            ex_valid [2];
  logic            ex_ill   [2];
  id_ex_payload_t  pay      [2];
  logic [4:0]      rs1a     [2];
  logic [4:0]      rs2a     [2];
  logic [31:0]     rd1      [2];
  logic [31:0]     rd2      [2];

  assign pin = {cur.pc, cur.instr};
  assign rd1[0] = rf[rs1a[0]];
  assign rd2[0] = rf[rs2a[0]];
  assign rd1[1] = rf[rs1a[1]];
  assign rd2[1] = rf[rs2a[1]];

  rv32i_id_pipe_stage #(.NUM_FWD(2), .LOAD_USE_STALL(1'b1), .ILLEGAL_PASS(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .if_valid_i(v_in), .if_ready_o(if_ready[0]),
    .if_payload_i(pin), .flush_i(fl_in), .rf_rs1_addr_o(rs1a[0]), .rf_rs2_addr_o(rs2a[0]),
    .rf_rs1_data_i(rd1[0]), .rf_rs2_data_i(rd2[0]), .fwd_valid_i(fv), .fwd_rd_i(frd),
    .fwd_data_i(fd), .ex_valid_o(ex_valid[0]), .ex_ready_i(rdy_in), .ex_payload_o(pay[0]),
    .ex_illegal_o(ex_ill[0]), .hazard_stall_o(hz[0])
  );

  rv32i_id_pipe_stage #(.NUM_FWD(2), .LOAD_USE_STALL(1'b1), .ILLEGAL_PASS(1'b0)) dut_np (
    .clk_i(clk), .rst_ni(rst_n), .if_valid_i(v_in), .if_ready_o(if_ready[1]),
    .if_payload_i(pin), .flush_i(fl_in), .rf_rs1_addr_o(rs1a[1]), .rf_rs2_addr_o(rs2a[1]),
    .rf_rs1_data_i(rd1[1]), .rf_rs2_data_i(rd2[1]), .fwd_valid_i(fv), .fwd_rd_i(frd),
    .fwd_data_i(fd), .ex_valid_o(ex_valid[1]), .ex_ready_i(rdy_in), .ex_payload_o(pay[1]),
    .ex_illegal_o(ex_ill[1]), .hazard_stall_o(hz[1])
  );

  int checks = 0;
  int errors = 0;
  int hz_cnt = 0;
  logic accepted;

  logic        mv  [2];
  logic        mil [2];
  tx_t         mt  [2];
  logic [31:0] m1  [2];
  logic [31:0] m2  [2];

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [4:0] f_rd(input tx_t t);  return t.instr[11:7];  endfunction
  function automatic logic [4:0] f_rs1(input tx_t t); return t.instr[19:15]; endfunction
  function automatic logic [4:0] f_rs2(input tx_t t); return t.instr[24:20]; endfunction
  function automatic logic f_wr(input tx_t t);
    return t.kind inside {K_ADDI, K_ADD, K_LW, K_LUI};
  endfunction
  function automatic logic f_use1(input tx_t t);
    return t.kind inside {K_ADDI, K_ADD, K_LW, K_SW, K_BEQ};
  endfunction
  function automatic logic f_use2(input tx_t t);
    return t.kind inside {K_ADD, K_SW, K_BEQ};
  endfunction

  function automatic logic [31:0] resolve(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = 0; i < 2; i++)
      if (fv[i] && frd[i] == a) return fd[i];
    return rf[a];
  endfunction

  function automatic tx_t make(input kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] r, input logic [31:0] pc);
    tx_t t;
    t.kind = k;
    t.pc   = pc;
    case (k)
      K_ADDI: begin t.imm = {{20{r[11]}}, r[11:0]}; t.instr = {t.imm[11:0], rs1, 3'b000, rd, 7'h13}; end
      K_ADD:  begin t.imm = 32'd0; t.instr = {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; end
      K_LW:   begin t.imm = {{20{r[11]}}, r[11:0]}; t.instr = {t.imm[11:0], rs1, 3'b010, rd, 7'h03}; end
      K_SW:   begin t.imm = {{20{r[11]}}, r[11:0]};
                    t.instr = {t.imm[11:5], rs2, rs1, 3'b010, t.imm[4:0], 7'h23}; end
      K_BEQ:  begin t.imm = {{19{r[12]}}, r[12:1], 1'b0};
                    t.instr = {t.imm[12], t.imm[10:5], rs2, rs1, 3'b000, t.imm[4:1], t.imm[11], 7'h63}; end
      K_LUI:  begin t.imm = {r[31:12], 12'h000}; t.instr = {t.imm[31:12], rd, 7'h37}; end
      default: begin t.imm = 32'd0; t.instr = r[0] ? 32'hFFFF_FFFF : 32'h0000_0000; end
    endcase
    return t;
  endfunction

  function automatic tx_t rand_tx(input logic [31:0] pc);
    return make(kind_t'($urandom_range(0, 6)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom, pc);
  endfunction

  task automatic check_regs();
    for (int d = 0; d < 2; d++) begin
      check("ex_valid", d, ex_valid[d], mv[d]);
      check("ex_illegal", d, ex_ill[d], mil[d]);
      if (mv[d]) begin
        check("pc", d, pay[d].pc, mt[d].pc);
        check("pc_plus4", d, pay[d].pc_plus4, mt[d].pc + 32'd4);
        check("instr", d, pay[d].instr, mt[d].instr);
        check("imm", d, pay[d].imm, mt[d].imm);
        check("rd_addr", d, pay[d].rd_addr, f_rd(mt[d]));
        check("rs1_data", d, pay[d].rs1_data, m1[d]);
        check("rs2_data", d, pay[d].rs2_data, m2[d]);
        check("reg_write", d, pay[d].reg_write, f_wr(mt[d]));
        check("mem_read", d, pay[d].mem_read, mt[d].kind == K_LW);
        check("mem_write", d, pay[d].mem_write, mt[d].kind == K_SW);
        check("branch", d, pay[d].branch, mt[d].kind == K_BEQ);
      end else begin
        check("payload_clear", d, pay[d] == '0, 1);
      end
    end
  endtask

  // One clock: check the combinational outputs, predict the edge, check the registers.
  task automatic cycle();
    logic hz_e [2];
    logic rdy_e [2];
    logic nv [2];
    logic nil [2];
    logic ld, ld_new [2];
    logic [31:0] r1, r2;
    #1;
    r1 = resolve(f_rs1(cur));
    r2 = resolve(f_rs2(cur));
    check("rf_rs1_addr", 0, rs1a[0], f_rs1(cur));
    check("rf_rs2_addr", 0, rs2a[0], f_rs2(cur));
    for (int d = 0; d < 2; d++) begin
      ld = !mv[d] || rdy_in;
      hz_e[d] = !fl_in && v_in && mv[d] && mt[d].kind == K_LW && f_rd(mt[d]) != 5'd0 &&
                ((f_use1(cur) && f_rs1(cur) == f_rd(mt[d])) ||
                 (f_use2(cur) && f_rs2(cur) == f_rd(mt[d])));
      rdy_e[d] = fl_in || (ld && !hz_e[d]);
      check("hazard_stall", d, hz[d], hz_e[d]);
      check("if_ready", d, if_ready[d], rdy_e[d]);
      nv[d] = mv[d];
      nil[d] = mil[d];
      ld_new[d] = 1'b0;
      if (fl_in || (ld && hz_e[d])) begin
        nv[d] = 1'b0;
        nil[d] = 1'b0;
      end else if (ld) begin
        nv[d] = v_in && (cur.kind != K_ILL || d == 0);
        nil[d] = nv[d] && cur.kind == K_ILL;
        ld_new[d] = nv[d];
      end
    end
    if (hz_e[0]) hz_cnt++;
    accepted = v_in && rdy_e[0];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mv[d] = nv[d];
      mil[d] = nil[d];
      if (ld_new[d]) begin
        mt[d] = cur;
        m1[d] = r1;
        m2[d] = r2;
      end
    end
    check_regs();
    if (accepted)
      $display("TX accept%s pc=%h instr=%h kind=%s", fl_in ? "+flush" : "", cur.pc, cur.instr, cur.kind.name());
    @(negedge clk);
  endtask

  task automatic send(input tx_t t);
    int n = 0;
    cur = t;
    v_in = 1'b1;
    accepted = 1'b0;
    while (!accepted && n < 16) begin
      cycle();
      n++;
    end
    check("send_timeout", 0, accepted, 1);
    v_in = 1'b0;
  endtask

  initial begin
    id_ex_payload_t held;
    int h0;
    logic [31:0] pc;
    rst_n = 1'b0;
    v_in = 1'b0; rdy_in = 1'b1; fl_in = 1'b0;
    fv = '0; frd = '0; fd = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_0000;
    rf[5] = 32'h0000_1111;
    cur = make(K_ADDI, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; mil[d] = 1'b0; mt[d] = cur; m1[d] = 32'd0; m2[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_valid", d, ex_valid[d], 0);
      check("reset_illegal", d, ex_ill[d], 0);
      check("reset_payload", d, pay[d] == '0, 1);
    end
    rst_n = 1'b1;

    send(make(K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h100));
    check("addi_imm", 0, pay[0].imm, 32'd5);
    check("addi_rd", 0, pay[0].rd_addr, 32'd1);
    check("addi_pc4", 0, pay[0].pc_plus4, 32'h104);

    send(make(K_LW, 5'd2, 5'd1, 5'd0, 32'd0, 32'h104));
    h0 = hz_cnt;
    send(make(K_ADD, 5'd3, 5'd2, 5'd2, 32'd0, 32'h108));
    check("loaduse_bubbles", 0, hz_cnt - h0, 1);
    check("add_issued", 0, pay[0].pc, 32'h108);

    fv = 2'b11; frd[0] = 5'd5; frd[1] = 5'd5; fd[0] = 32'hAAAA; fd[1] = 32'hBBBB;
    send(make(K_ADD, 5'd6, 5'd5, 5'd0, 32'd0, 32'h10C));
    check("fwd_prio", 0, pay[0].rs1_data, 32'hAAAA);
    frd[0] = 5'd0; frd[1] = 5'd0;
    send(make(K_ADDI, 5'd7, 5'd0, 5'd0, 32'd1, 32'h110));
    check("fwd_x0", 0, pay[0].rs1_data, 32'd0);
    fv = 2'b00;

    rdy_in = 1'b0;
    v_in = 1'b1;
    cur = make(K_ADDI, 5'd8, 5'd1, 5'd0, 32'd9, 32'h114);
    held = pay[0];
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_no_accept", 0, accepted, 0);
      check("stall_hold", 0, pay[0] == held, 1);
    end
    rdy_in = 1'b1;
    send(cur);
    check("drain_pc", 0, pay[0].pc, 32'h114);

    send(make(K_ILL, 5'd0, 5'd0, 5'd0, 32'd1, 32'h118));
    check("ill_valid", 0, ex_valid[0], 1);
    check("ill_flag", 0, ex_ill[0], 1);
    check("ill_regwrite", 0, pay[0].reg_write, 0);
    check("ill_drop", 1, ex_valid[1], 0);

    send(make(K_LW, 5'd9, 5'd1, 5'd0, 32'd4, 32'h11C));
    cur = make(K_ADD, 5'd10, 5'd9, 5'd9, 32'd0, 32'h120);
    v_in = 1'b1;
    fl_in = 1'b1;
    cycle();
    fl_in = 1'b0;
    check("flush_accept", 0, accepted, 1);
    check("flush_kill", 0, ex_valid[0], 0);

    pc = 32'h200;
    cur = rand_tx(pc);
    for (int n = 0; n < 400; n++) begin
      v_in = ($urandom_range(0, 9) < 8);
      rdy_in = ($urandom_range(0, 3) != 0);
      fl_in = ($urandom_range(0, 19) == 0);
      fv = 2'($urandom);
      frd[0] = 5'($urandom_range(0, 7)); frd[1] = 5'($urandom_range(0, 7));
      fd[0] = $urandom; fd[1] = $urandom;
      cycle();
      if (accepted) begin
        pc = pc + 32'd4;
        cur = rand_tx(pc);
      end
    end
    fl_in = 1'b0; fv = 2'b00;
    rdy_in = 1'b1;

    send(make(K_ADDI, 5'd4, 5'd1, 5'd0, 32'd3, 32'h300));
    v_in = 1'b1;
    cur = make(K_LW, 5'd4, 5'd4, 5'd0, 32'd0, 32'h304);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("async_rst_valid", d, ex_valid[d], 0);
      check("async_rst_illegal", d, ex_ill[d], 0);
      check("async_rst_payload", d, pay[d] == '0, 1);
      mv[d] = 1'b0;
      mil[d] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      v_in = 1'b1;
      cycle();
      if (accepted) cur = rand_tx(cur.pc + 32'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
